// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// Load/store unit: takes EX results and either passes them straight to writeback
// or performs one aligned bus access, with a bounded wait on mem_ready.
module load_store_unit #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic        reg_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [1:0]  exc
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    state_t      state, state_next;
    logic [CW-1:0] tcnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        ld_q;
    logic [4:0]  rd_q;
    logic        rw_q;

    logic        accept;
    logic        is_mem;
    logic        illegal;
    logic        misaligned;
    logic [1:0]  exc_in;
    logic        timeout_hit;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata;
    logic [31:0] rd_shift;
    logic [31:0] load_val;

    assign in_ready    = (state == IDLE);
    assign accept      = in_valid & ~flush & (state == IDLE);
    assign is_mem      = is_load | is_store;
    assign timeout_hit = (tcnt == CW'(MEM_TIMEOUT - 1));
    assign rd_shift    = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        exc_in     = 2'b00;
        st_strb    = 4'b0000;
        st_wdata   = 32'h0;
        if (is_load)
            illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else if (is_store)
            illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
        // funct3[1:0] encodes access width for every legal code
        if (funct3[1:0] == 2'b01)
            misaligned = alu_result[0];
        else if (funct3[1:0] == 2'b10)
            misaligned = (alu_result[1:0] != 2'b00);
        if (illegal)
            exc_in = 2'b11;
        else if (misaligned)
            exc_in = 2'b01;
        case (funct3[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << alu_result[1:0];
                st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                st_strb  = alu_result[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = store_data;
            end
        endcase
    end

    always_comb begin
        case (f3_q)
            3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_val = {24'h0, rd_shift[7:0]};
            3'b101:  load_val = {16'h0, rd_shift[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (accept && is_mem && exc_in == 2'b00) state_next = ACCESS;
            ACCESS: if (mem_ready || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt      <= '0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            ld_q      <= 1'b0;
            rd_q      <= 5'd0;
            rw_q      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'b0000;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= 32'h0;
            exc       <= 2'b00;
        end else begin
            wb_valid <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    wb_rd <= rd;
                    if (!is_mem) begin
                        wb_valid <= 1'b1;
                        wb_data  <= alu_result;
                        wb_we    <= reg_write & (rd != 5'd0);
                        exc      <= 2'b00;
                    end else if (exc_in != 2'b00) begin
                        wb_valid <= 1'b1;
                        wb_data  <= alu_result;
                        wb_we    <= 1'b0;
                        exc      <= exc_in;
                    end else begin
                        mem_req   <= 1'b1;
                        mem_we    <= ~is_load;
                        mem_addr  <= {alu_result[31:2], 2'b00};
                        mem_wdata <= is_load ? 32'h0 : st_wdata;
                        mem_wstrb <= is_load ? 4'b0000 : st_strb;
                        f3_q      <= funct3;
                        off_q     <= alu_result[1:0];
                        ld_q      <= is_load;
                        rd_q      <= rd;
                        rw_q      <= reg_write;
                        tcnt      <= '0;
                    end
                end
            end else begin
                // Flush is deliberately ignored here: the bus access must finish
                if (mem_ready || timeout_hit) begin
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_wstrb <= 4'b0000;
                    wb_valid  <= 1'b1;
                    wb_rd     <= rd_q;
                    tcnt      <= '0;
                    if (mem_ready) begin
                        wb_we   <= ld_q & rw_q & (rd_q != 5'd0);
                        wb_data <= ld_q ? load_val : 32'h0;
                        exc     <= 2'b00;
                    end else begin
                        wb_we   <= 1'b0;
                        wb_data <= 32'h0;
                        exc     <= 2'b10;
                    end
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// Directed self-checking bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush;
    logic [31:0] alu_result, store_data;
    logic        is_load, is_store;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  exc;

    int compared   = 0;
    int mismatched = 0;
    int reqCycles;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .alu_result(alu_result), .store_data(store_data),
        .is_load(is_load), .is_store(is_store), .funct3(funct3),
        .rd(rd), .reg_write(reg_write),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .exc(exc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents one op for a single accept edge, then withdraws it
    task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [4:0] dst, input logic rw);
        in_valid   = 1'b1;
        is_load    = ld;
        is_store   = st;
        funct3     = f3;
        alu_result = addr;
        store_data = sdata;
        rd         = dst;
        reg_write  = rw;
        tick();
        in_valid = 1'b0;
    endtask

    // Holds mem_ready low for 'waits' cycles, then completes the access
    task automatic runAccess(input int waits, input logic [31:0] rdata);
        mem_rdata = rdata;
        mem_ready = 1'b0;
        for (int i = 0; i < waits; i++) tick();
        checkOutput("req_before_ready", {31'h0, mem_req}, 32'd1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; flush = 0; alu_result = 0; store_data = 0;
        is_load = 0; is_store = 0; funct3 = 0; rd = 0; reg_write = 0;
        mem_ready = 0; mem_rdata = 0;
        tick(); tick();
        checkOutput("rst_in_ready", {31'h0, in_ready}, 32'd1);
        checkOutput("rst_mem_req",  {31'h0, mem_req}, 32'd0);
        checkOutput("rst_wb_valid", {31'h0, wb_valid}, 32'd0);
        checkOutput("rst_wb_data",  wb_data, 32'h0);
        checkOutput("rst_wstrb",    {28'h0, mem_wstrb}, 32'h0);
        rst = 1'b0;
        tick();

        applyStimulus(0, 0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
        checkOutput("pt_valid", {31'h0, wb_valid}, 32'd1);
        checkOutput("pt_data",  wb_data, 32'h1234);
        checkOutput("pt_we",    {31'h0, wb_we}, 32'd1);
        checkOutput("pt_exc",   {30'h0, exc}, 32'd0);
        checkOutput("pt_rd",    {27'h0, wb_rd}, 32'd5);
        tick();
        checkOutput("pt_pulse", {31'h0, wb_valid}, 32'd0);

        applyStimulus(0, 0, 3'b000, 32'h77, 32'h0, 5'd0, 1'b1);
        checkOutput("pt_rd0_we", {31'h0, wb_we}, 32'd0);
        tick();

        applyStimulus(1, 0, 3'b000, 32'h103, 32'h0, 5'd7, 1'b1);
        checkOutput("lb_req",      {31'h0, mem_req}, 32'd1);
        checkOutput("lb_addr",     mem_addr, 32'h100);
        checkOutput("lb_we",       {31'h0, mem_we}, 32'd0);
        checkOutput("lb_in_ready", {31'h0, in_ready}, 32'd0);
        runAccess(2, 32'h80FFFFFF);
        checkOutput("lb_wb_valid", {31'h0, wb_valid}, 32'd1);
        checkOutput("lb_data",     wb_data, 32'hFFFFFF80);
        checkOutput("lb_wb_we",    {31'h0, wb_we}, 32'd1);
        checkOutput("lb_req_drop", {31'h0, mem_req}, 32'd0);
        tick();

        applyStimulus(1, 0, 3'b100, 32'h103, 32'h0, 5'd7, 1'b1);
        runAccess(2, 32'h80FFFFFF);
        checkOutput("lbu_data", wb_data, 32'h00000080);
        tick();

        applyStimulus(1, 0, 3'b001, 32'h102, 32'h0, 5'd8, 1'b1);
        runAccess(0, 32'h80FFFFFF);
        checkOutput("lh_data", wb_data, 32'hFFFF80FF);
        tick();
        applyStimulus(1, 0, 3'b101, 32'h102, 32'h0, 5'd8, 1'b1);
        runAccess(1, 32'h80FFFFFF);
        checkOutput("lhu_data", wb_data, 32'h000080FF);
        tick();

        applyStimulus(0, 1, 3'b001, 32'h202, 32'hABCD1234, 5'd3, 1'b1);
        checkOutput("sh_strb",  {28'h0, mem_wstrb}, 32'hC);
        checkOutput("sh_wdata", mem_wdata, 32'h12341234);
        checkOutput("sh_we",    {31'h0, mem_we}, 32'd1);
        checkOutput("sh_addr",  mem_addr, 32'h200);
        runAccess(1, 32'h0);
        checkOutput("sh_wb_valid", {31'h0, wb_valid}, 32'd1);
        checkOutput("sh_wb_we",    {31'h0, wb_we}, 32'd0);
        checkOutput("sh_exc",      {30'h0, exc}, 32'd0);
        tick();

        applyStimulus(0, 1, 3'b000, 32'h201, 32'h000000EF, 5'd3, 1'b0);
        checkOutput("sb_strb",  {28'h0, mem_wstrb}, 32'h2);
        checkOutput("sb_wdata", mem_wdata, 32'hEFEFEFEF);
        flush = 1'b1;
        runAccess(1, 32'h0);
        flush = 1'b0;
        checkOutput("sb_flush_done", {31'h0, wb_valid}, 32'd1);
        tick();

        applyStimulus(0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 5'd3, 1'b0);
        checkOutput("sw_strb",  {28'h0, mem_wstrb}, 32'hF);
        checkOutput("sw_wdata", mem_wdata, 32'hCAFEF00D);
        runAccess(0, 32'h0);
        tick();

        applyStimulus(1, 0, 3'b010, 32'h101, 32'h0, 5'd9, 1'b1);
        checkOutput("mis_req",   {31'h0, mem_req}, 32'd0);
        checkOutput("mis_valid", {31'h0, wb_valid}, 32'd1);
        checkOutput("mis_exc",   {30'h0, exc}, 32'd1);
        checkOutput("mis_we",    {31'h0, wb_we}, 32'd0);
        checkOutput("mis_data",  wb_data, 32'h101);
        tick();

        applyStimulus(1, 0, 3'b011, 32'h100, 32'h0, 5'd9, 1'b1);
        checkOutput("ill_ld_exc", {30'h0, exc}, 32'd3);
        checkOutput("ill_ld_req", {31'h0, mem_req}, 32'd0);
        tick();
        applyStimulus(0, 1, 3'b101, 32'h101, 32'h0, 5'd9, 1'b1);
        checkOutput("ill_st_prio", {30'h0, exc}, 32'd3);
        tick();

        in_valid = 1'b1; flush = 1'b1; is_load = 1'b1; funct3 = 3'b010; alu_result = 32'h100;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        checkOutput("flush_req",   {31'h0, mem_req}, 32'd0);
        checkOutput("flush_valid", {31'h0, wb_valid}, 32'd0);

        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checkOutput("idle_ready_ignored", {31'h0, wb_valid}, 32'd0);

        applyStimulus(1, 0, 3'b010, 32'h400, 32'h0, 5'd4, 1'b1);
        reqCycles = 0;
        while (mem_req && reqCycles < 40) begin
            reqCycles++;
            tick();
        end
        checkOutput("to_req_cycles", reqCycles, 32'd16);
        checkOutput("to_valid",      {31'h0, wb_valid}, 32'd1);
        checkOutput("to_exc",        {30'h0, exc}, 32'd2);
        checkOutput("to_we",         {31'h0, wb_we}, 32'd0);
        checkOutput("to_in_ready",   {31'h0, in_ready}, 32'd1);
        tick();

        applyStimulus(1, 0, 3'b010, 32'h500, 32'h0, 5'd0, 1'b1);
        runAccess(0, 32'h12345678);
        checkOutput("rd0_valid", {31'h0, wb_valid}, 32'd1);
        checkOutput("rd0_we",    {31'h0, wb_we}, 32'd0);
        checkOutput("lw_data",   wb_data, 32'h12345678);
        tick();

        applyStimulus(1, 0, 3'b010, 32'h600, 32'h0, 5'd6, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rstmid_req",   {31'h0, mem_req}, 32'd0);
        checkOutput("rstmid_valid", {31'h0, wb_valid}, 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checkOutput("rstmid_no_wb", {31'h0, wb_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum cycles mem_req stays high awaiting mem_ready before abort.
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  EX result presented.
REQ-006 in_ready  out  1  unit accepts input this cycle.
REQ-007 flush  in  1  drop the presented input.
REQ-008 alu_result  in  32  ALU result; memory address for load/store.
REQ-009 store_data  in  32  rs2 value.
REQ-010 is_load, is_store  in  1 each  op class; both low = ALU passthrough.
REQ-011 funct3  in  3  RV32 load/store width code.
REQ-012 rd  in  5  destination register.
REQ-013 reg_write  in  1  op writes rd.
REQ-014 mem_req, mem_we  out  1 each  bus request and write enable.
REQ-015 mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
REQ-016 mem_wdata  out  32 and mem_wstrb  out  4  lane-positioned store data and byte strobes.
REQ-017 mem_ready  in  1 and mem_rdata  in  32  bus completion and read word.
REQ-018 wb_valid, wb_we  out  1 each; wb_rd  out  5; wb_data  out  32  writeback result.
REQ-019 exc  out  2  cause, valid with wb_valid: 00 none, 01 misaligned, 10 bus timeout, 11 illegal funct3.

Function
REQ-020 SHALL implement FSM IDLE, ACCESS; in_ready = (state==IDLE).
REQ-021 SHALL accept in IDLE when in_valid & ~flush; flush high means no accept, no side effect.
REQ-022 Passthrough accept SHALL produce wb_valid next cycle, wb_data=alu_result, wb_we=reg_write & (rd!=0), exc=00; state stays IDLE.
REQ-023 Load/store accept with legal funct3 and aligned address SHALL register operands and enter ACCESS; mem_req high from next cycle until mem_ready sampled high.
REQ-024 Legal funct3: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW; else exc=11.
REQ-025 Misaligned: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL give exc=01; exc takes priority order 11 over 01.
REQ-026 Any exc SHALL issue no bus request and emit wb_valid next cycle with wb_we=0, wb_data=alu_result.
REQ-027 Stores: SB strb=4'b0001<<addr[1:0], wdata=byte replicated x4; SH strb=0011 (addr[1]=0) or 1100, wdata=half replicated x2; SW strb=1111; mem_we=1.
REQ-028 Loads: mem_we=0, mem_wstrb=0; byte/half selected by addr[1:0] from mem_rdata; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-029 On mem_ready in ACCESS: mem_req drops next cycle, state to IDLE, wb_valid one cycle later (next cycle); load wb_we=reg_write&(rd!=0); store wb_we=0; exc=00.
REQ-030 ACCESS load-to-wb latency SHALL be 2 + wait cycles from accept; mem_ready with zero wait in first ACCESS cycle is legal.
REQ-031 Timeout counter SHALL count ACCESS cycles; reaching MEM_TIMEOUT without mem_ready SHALL drop mem_req, return to IDLE, wb_valid with wb_we=0, exc=10.
REQ-032 flush during ACCESS SHALL NOT abort the transaction (bus side effects must complete).
REQ-033 wb_valid SHALL be a single-cycle pulse per accepted op; mem_addr/wdata/strb/we stable while mem_req high.
REQ-034 mem_ready outside ACCESS SHALL be ignored.

Reset
REQ-035 rst SHALL force IDLE, timeout counter 0, and mem_req, mem_we, wb_valid, wb_we, mem_wstrb, exc, wb_rd, wb_data, mem_addr, mem_wdata all 0.
REQ-036 rst mid-ACCESS SHALL drop mem_req next cycle with no wb_valid for the aborted op.

Verification
REQ-037 Passthrough: alu_result=0x1234, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_we=1, exc=00.
REQ-038 LB: addr=0x103, mem_rdata=0x80FFFFFF, mem_ready after 2 waits -> mem_addr=0x100, wb_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-039 SH: addr=0x202, store_data=0xABCD1234 -> mem_wstrb=1100, mem_wdata=0x12341234, mem_we=1, wb_we=0.
REQ-040 LW addr=0x101 -> no mem_req, wb_valid next cycle, exc=01, wb_we=0; funct3=011 load -> exc=11.
REQ-041 Timeout: mem_ready held 0 -> mem_req high exactly MEM_TIMEOUT cycles, then exc=10, in_ready=1.
REQ-042 rd=0 load completes -> wb_we=0; rst asserted in ACCESS -> mem_req=0 next cycle, no wb_valid.
